// File: rtl/gate_bist_pkg.sv
// Shared types and constants for the gate BIST sequencer.
package gate_bist_pkg;

    typedef enum logic {
        IDLE   = 1'b0,
        SETTLE = 1'b1
    } state_t;

    // Expected truth tables: bit i = y for {a,b} = i.
    localparam logic [3:0] TT_AND  = 4'b1000;
    localparam logic [3:0] TT_OR   = 4'b1110;
    localparam logic [3:0] TT_NAND = 4'b0111;
    localparam logic [3:0] TT_NOR  = 4'b0001;
    localparam logic [3:0] TT_XOR  = 4'b0110;
    localparam logic [3:0] TT_XNOR = 4'b1001;

    localparam int NUM_VEC = 4;

endpackage

// File: rtl/gate_bist_timer.sv
// Settle down-counter: load starts a SETTLE_CYCLES window, expire marks its last cycle.
module gate_bist_timer #(
    parameter int unsigned SETTLE_CYCLES = 2
) (
    input  logic clk,
    input  logic rst_n,
    input  logic load,
    output logic expire
);

    localparam int W = $clog2(SETTLE_CYCLES + 1);
    localparam logic [W-1:0] LOAD_VAL = W'(SETTLE_CYCLES - 1);

    logic [W-1:0] cnt;

    // Reload on request, otherwise count down and rest at zero.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)
            cnt <= '0;
        else if (load)
            cnt <= LOAD_VAL;
        else if (cnt != '0)
            cnt <= cnt - 1'b1;
    end

    assign expire = (cnt == '0);

endmodule

// File: rtl/gate_bist.sv
// BIST sequencer: walks a 2-input gate through its truth table and checks y.
module gate_bist
    import gate_bist_pkg::*;
#(
    parameter int unsigned SETTLE_CYCLES = 2,
    parameter logic [3:0]  EXPECT_TT     = TT_OR
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       start,
    output logic       dut_a,
    output logic       dut_b,
    input  logic       dut_y,
    output logic       busy,
    output logic       done,
    output logic       pass,
    output logic [2:0] err_count,
    output logic [3:0] fail_vec,
    output logic [3:0] observed_tt
);

    state_t     state, state_nxt;
    logic [1:0] vec;
    logic       expire;
    logic       accept, sample, last, mismatch, load;
    logic [2:0] err_nxt;

    gate_bist_timer #(.SETTLE_CYCLES(SETTLE_CYCLES)) u_timer (
        .clk    (clk),
        .rst_n  (rst_n),
        .load   (load),
        .expire (expire)
    );

    // Next-state and per-cycle control strobes.
    always_comb begin
        state_nxt = state;
        accept    = 1'b0;
        sample    = 1'b0;
        last      = 1'b0;
        case (state)
            IDLE: begin
                if (start) begin
                    accept    = 1'b1;
                    state_nxt = SETTLE;
                end
            end
            SETTLE: begin
                if (expire) begin
                    sample = 1'b1;
                    if (vec == 2'(NUM_VEC - 1)) begin
                        last      = 1'b1;
                        state_nxt = IDLE;
                    end
                end
            end
            default: state_nxt = IDLE;
        endcase
    end

    assign mismatch = dut_y != EXPECT_TT[vec];
    assign err_nxt  = err_count + 3'(mismatch);
    assign load     = accept | (sample & ~last);

    // State register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state <= IDLE;
        else        state <= state_nxt;
    end

    // Vector driver and result registers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            vec         <= '0;
            dut_a       <= 1'b0;
            dut_b       <= 1'b0;
            busy        <= 1'b0;
            done        <= 1'b0;
            pass        <= 1'b0;
            err_count   <= '0;
            fail_vec    <= '0;
            observed_tt <= '0;
        end else begin
            done <= 1'b0;
            if (accept) begin
                busy           <= 1'b1;
                vec            <= '0;
                {dut_a, dut_b} <= 2'b00;
                pass           <= 1'b0;
                err_count      <= '0;
                fail_vec       <= '0;
                observed_tt    <= '0;
            end else if (sample) begin
                observed_tt[vec] <= dut_y;
                if (mismatch) begin
                    fail_vec[vec] <= 1'b1;
                    err_count     <= err_nxt;
                end
                if (last) begin
                    busy           <= 1'b0;
                    done           <= 1'b1;
                    {dut_a, dut_b} <= 2'b00;
                    pass           <= (err_nxt == 3'd0);
                end else begin
                    vec            <= vec + 2'd1;
                    {dut_a, dut_b} <= vec + 2'd1;
                end
            end
        end
    end

endmodule

// File: tb/tb_gate_bist.sv
// Self-checking bench: two sequencers (settle 2 / OR, settle 1 / XOR) each driving a modelled gate.
module tb_gate_bist;
    import gate_bist_pkg::*;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    logic       st   [2];
    logic [3:0] gt   [2];
    logic       a    [2];
    logic       b    [2];
    logic       y    [2];
    logic       busy [2];
    logic       done [2];
    logic       pass [2];
    logic [2:0] err  [2];
    logic [3:0] fv   [2];
    logic [3:0] obs  [2];

    int passed = 0;
    int total  = 0;

    localparam int         SET [2] = '{2, 1};
    localparam logic [3:0] EXP [2] = '{TT_OR, TT_XOR};

    // Gate under test: arbitrary truth table looked up by {a,b}.
    assign y[0] = gt[0][{a[0], b[0]}];
    assign y[1] = gt[1][{a[1], b[1]}];

    gate_bist #(.SETTLE_CYCLES(2), .EXPECT_TT(TT_OR)) u0 (
        .clk(clk), .rst_n(rst_n), .start(st[0]), .dut_a(a[0]), .dut_b(b[0]), .dut_y(y[0]),
        .busy(busy[0]), .done(done[0]), .pass(pass[0]), .err_count(err[0]),
        .fail_vec(fv[0]), .observed_tt(obs[0]));

    gate_bist #(.SETTLE_CYCLES(1), .EXPECT_TT(TT_XOR)) u1 (
        .clk(clk), .rst_n(rst_n), .start(st[1]), .dut_a(a[1]), .dut_b(b[1]), .dut_y(y[1]),
        .busy(busy[1]), .done(done[1]), .pass(pass[1]), .err_count(err[1]),
        .fail_vec(fv[1]), .observed_tt(obs[1]));

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act === exp) passed++;
        else $display("FAIL %s: got %0h, expected %0h", name, act, exp);
    endtask

    task automatic chk_results(input int s, input string tag, input logic [2:0] e_err,
                               input logic [3:0] e_fv, input logic [3:0] e_obs, input logic e_pass);
        chk({tag, " err_count"}, 32'(err[s]), 32'(e_err));
        chk({tag, " fail_vec"},  32'(fv[s]),  32'(e_fv));
        chk({tag, " observed"},  32'(obs[s]), 32'(e_obs));
        chk({tag, " pass"},      32'(pass[s]), 32'(e_pass));
    endtask

    // Spec-level model: a whole run reduces to comparing two truth tables.
    task automatic chk_model(input int s, input string tag, input logic [3:0] g);
        logic [3:0] f;
        f = g ^ EXP[s];
        chk_results(s, tag, 3'($countones(f)), f, g, f == 4'b0000);
    endtask

    // One run from a start pulse: checks vector stepping, busy window and a single done pulse.
    // poke pulses start again in the second busy cycle; it must have no effect.
    task automatic run(input int s, input logic [3:0] g, input bit poke, input string tag);
        int  n;
        bit  bad;
        n   = SET[s];
        bad = 1'b0;
        @(negedge clk);
        gt[s] = g;
        st[s] = 1'b1;
        @(posedge clk);
        #1 st[s] = 1'b0;
        for (int k = 0; k < 4 * n; k++) begin
            @(negedge clk);
            if (busy[s] !== 1'b1 || done[s] !== 1'b0 || {a[s], b[s]} !== 2'(k / n)) bad = 1'b1;
            if (poke && k == 1) st[s] = 1'b1;
            @(posedge clk);
            #1 st[s] = 1'b0;
        end
        @(negedge clk);
        chk({tag, " sequence"}, 32'(bad), 32'd0);
        chk({tag, " done"}, {29'd0, done[s], busy[s], a[s] | b[s]}, 32'b100);
        @(negedge clk);
        chk({tag, " done low"}, {30'd0, done[s], busy[s]}, 32'd0);
    endtask

    typedef struct {
        logic [3:0] gate;
        logic [2:0] e_err;
        logic [3:0] e_fv;
        logic [3:0] e_obs;
        logic       e_pass;
        string      name;
    } vec_t;

    vec_t tbl [6];

    initial begin
        int n;
        int s;
        bit seen;
        logic [3:0] g;

        tbl[0] = '{4'b1110, 3'd0, 4'b0000, 4'b1110, 1'b1, "or"};
        tbl[1] = '{4'b0000, 3'd3, 4'b1110, 4'b0000, 1'b0, "tie0"};
        tbl[2] = '{4'b1000, 3'd2, 4'b0110, 4'b1000, 1'b0, "and"};
        tbl[3] = '{4'b0110, 3'd1, 4'b1000, 4'b0110, 1'b0, "xor"};
        tbl[4] = '{4'b0001, 3'd4, 4'b1111, 4'b0001, 1'b0, "nor"};
        tbl[5] = '{4'b1111, 3'd1, 4'b0001, 4'b1111, 1'b0, "tie1"};

        st[0] = 1'b0; st[1] = 1'b0;
        gt[0] = TT_OR; gt[1] = TT_XOR;

        // Reset state
        repeat (3) @(negedge clk);
        chk("reset outputs", {a[0], b[0], busy[0], done[0], pass[0], err[0], fv[0], obs[0]}, 32'd0);
        rst_n = 1'b1;
        @(negedge clk);
        chk("idle after release", {busy[0], done[0], busy[1], done[1]}, 32'd0);

        // Table of gates against the OR expectation, settle = 2
        foreach (tbl[i]) begin
            run(0, tbl[i].gate, 1'b0, tbl[i].name);
            chk_results(0, tbl[i].name, tbl[i].e_err, tbl[i].e_fv, tbl[i].e_obs, tbl[i].e_pass);
        end

        // Results hold in idle
        repeat (5) @(negedge clk);
        chk("hold err_count", 32'(err[0]), 32'd1);

        // Settle = 1, correct XOR gate, start poked mid-run
        run(1, TT_XOR, 1'b1, "s1 poke");
        chk_results(1, "s1 poke", 3'd0, 4'b0000, TT_XOR, 1'b1);

        // Reset while vector 2 is driven
        @(negedge clk);
        gt[0] = TT_OR;
        st[0] = 1'b1;
        @(posedge clk);
        #1 st[0] = 1'b0;
        repeat (5) @(posedge clk);
        @(negedge clk);
        chk("vec2 driven", {30'd0, a[0], b[0]}, 32'b10);
        rst_n = 1'b0;
        #1;
        chk("abort clears", {a[0], b[0], busy[0], done[0], pass[0], err[0], fv[0], obs[0]}, 32'd0);
        @(negedge clk);
        rst_n = 1'b1;
        seen = 1'b0;
        repeat (12) begin
            @(negedge clk);
            if (done[0] || busy[0]) seen = 1'b1;
        end
        chk("no done after abort", 32'(seen), 32'd0);
        run(0, TT_OR, 1'b0, "post reset");
        chk_results(0, "post reset", 3'd0, 4'b0000, 4'b1110, 1'b1);

        // Start held high: back-to-back runs, latest results only
        @(negedge clk);
        gt[0] = TT_OR;
        st[0] = 1'b1;
        n = 0;
        while (!done[0] && n < 40) begin
            @(negedge clk);
            n++;
        end
        chk("b2b first done seen", 32'(done[0]), 32'd1);
        chk_results(0, "b2b run1", 3'd0, 4'b0000, 4'b1110, 1'b1);
        gt[0] = TT_AND;
        n = 0;
        do begin
            @(negedge clk);
            n++;
        end while (!done[0] && n < 40);
        chk("b2b done interval", 32'(n), 32'(4 * SET[0] + 1));
        chk_results(0, "b2b run2", 3'd2, 4'b0110, 4'b1000, 1'b0);
        st[0] = 1'b0;
        @(negedge clk);
        chk("b2b stops", {30'd0, busy[0], done[0]}, 32'd0);

        // Randomized gates on both sequencers against the truth-table model
        for (int i = 0; i < 24; i++) begin
            s = i % 2;
            g = 4'($urandom_range(0, 15));
            run(s, g, 1'($urandom_range(0, 1)), $sformatf("rnd%0d", i));
            chk_model(s, $sformatf("rnd%0d", i), g);
        end

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule

// File: doc/gate_bist.md
Name: gate_bist

Overview:
- Built-in self-test sequencer for a 2-input, 1-output logic gate (the `or_gate` family).
- Acts as the stimulus/checking end of the gate interface:
  - drives the gate inputs `a`/`b` through all four truth-table vectors;
  - waits a programmable settle time, then samples the gate output `y`;
  - compares against an expected truth table and reports per-vector failures, an error count and pass/fail.
- Replaces simulation-only `$monitor` checking with synthesizable on-chip checking; sits beside any gate instance under test.

Parameters:
- SETTLE_CYCLES, 2, cycles from driving a vector to sampling `dut_y`; legal range 1..15.
- EXPECT_TT, 4'b1110, expected output per vector; bit i = expected `y` for `{a,b}` = i (default = OR).

Ports:
- clk  input  1  rising-edge clock
- rst_n  input  1  asynchronous active-low reset
- start  input  1  request a test run; sampled only when idle
- dut_a  output  1  gate input a
- dut_b  output  1  gate input b
- dut_y  input  1  gate output under test
- busy  output  1  high while a run is in progress
- done  output  1  one-cycle pulse when a run completes
- pass  output  1  high after a run with zero mismatches; held until the next accepted start
- err_count  output  3  number of mismatching vectors, 0..4
- fail_vec  output  4  bit i set if vector i mismatched
- observed_tt  output  4  bit i = sampled `dut_y` for vector i

Behaviour:
- Reset (async assert, sync release): state IDLE. All outputs 0 (`dut_a`, `dut_b`, `busy`, `done`, `pass`, `err_count`, `fail_vec`, `observed_tt`). Internal vector index and timer also 0.
- Reset asserted mid-run aborts immediately. No `done` pulse; results are cleared.
- FSM states: IDLE, SETTLE.
- IDLE, start=1 at an edge:
  - state->SETTLE, busy<=1, vec<=0, `{dut_a,dut_b}`<=2'b00, timer<=0;
  - `err_count`, `fail_vec`, `observed_tt`, `pass` cleared to 0.
- IDLE, start=0: hold; all result outputs keep their values.
- SETTLE, at each edge with timer != SETTLE_CYCLES-1: timer++.
- SETTLE, at the edge with timer == SETTLE_CYCLES-1 (sample edge):
  - `observed_tt[vec]`<=`dut_y`;
  - if `dut_y` != `EXPECT_TT[vec]`: `fail_vec[vec]`<=1, `err_count`++;
  - if vec != 3: vec++, `{dut_a,dut_b}`<=vec+1, timer<=0;
  - if vec == 3: state->IDLE, busy<=0, done<=1 for one cycle, `{dut_a,dut_b}`<=2'b00, pass<=(final `err_count`==0, including this vector's result).
- Vector order: 00, 01, 10, 11, with `dut_a` = vec[1] and `dut_b` = vec[0].
- Timing:
  - each vector is driven for exactly SETTLE_CYCLES cycles;
  - a run lasts 4*SETTLE_CYCLES cycles after the start edge;
  - `busy` is high for exactly those cycles.
- `start` while busy: ignored, with no effect on the run.
- `start` held high during the `done` cycle: accepted at the next edge, giving back-to-back runs. `done` then drops and results clear.
- `err_count` saturation is unnecessary: maximum value is 4, fits in 3 bits.
- `done` is 0 in every cycle other than the single completion cycle.

Decomposition:
- Package `gate_bist_pkg`:
  - FSM state enum (IDLE, SETTLE);
  - truth-table constants TT_AND=4'b1000, TT_OR=4'b1110, TT_NAND=4'b0111, TT_NOR=4'b0001, TT_XOR=4'b0110, TT_XNOR=4'b1001;
  - vector count constant NUM_VEC=4.
- Sub-module `gate_bist_timer`:
  - settle down-counter with load and expire outputs;
  - width $clog2(SETTLE_CYCLES+1).
- FSM, vector driver and result registers stay in the top level.

Test Plan:
- Connected to a correct `or_gate`, default parameters; pulse `start` -> `dut_a`/`dut_b` step 00,01,10,11, two cycles each; `done` pulses 8 cycles after the start edge; pass=1, err_count=0, fail_vec=0000, observed_tt=1110.
- `dut_y` tied 0, EXPECT_TT=TT_OR -> pass=0, err_count=3, fail_vec=1110, observed_tt=0000.
- AND gate under test with EXPECT_TT=TT_OR -> err_count=2, fail_vec=0110, observed_tt=1000, pass=0.
- SETTLE_CYCLES=1 with a correct gate -> each vector held 1 cycle; `done` 4 cycles after start; `start` pulsed mid-run is ignored (no restart, same timing).
- `rst_n` asserted while vector 2 is driven -> all outputs 0 immediately, no `done` pulse; a new `start` after release runs a full clean sequence.
- `start` held high continuously -> back-to-back runs; `done` pulses every 4*SETTLE_CYCLES+1 cycles; results reflect the latest run only.
